lmac_reg_rd_arb: RTL and testbench

LMAC_REG_RD_ARB -- requirements
Module: lmac_reg_rd_arb

---
 rtl/lmac_ctrl_pkg.sv | 18 +
 rtl/lmac_reg_rd_arb_if.sv | 31 +++
 rtl/lmac_rr_arb2.sv | 19 +
 rtl/lmac_reg_rd_arb.sv | 147 ++++++++++++++
 tb/tb_lmac_reg_rd_arb.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lmac_ctrl_pkg.sv
// Shared types and defaults for the MAC register-read arbiter.
package lmac_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } rd_state_e;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  localparam logic [31:0] DEF_ERR_DATA       = 32'hFFFF_FFFF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lmac_reg_rd_arb_if.sv
// Requester-side request/response bundle for the register-read arbiter.
interface lmac_reg_rd_arb_if;

  logic        req_valid_0;
  logic        req_valid_1;
  logic [15:0] req_addr_0;
  logic [15:0] req_addr_1;
  logic        req_ready_0;
  logic        req_ready_1;
  logic        rsp_valid_0;
  logic        rsp_valid_1;
  logic [31:0] rsp_data_0;
  logic [31:0] rsp_data_1;
  logic        rsp_err_0;
  logic        rsp_err_1;

  // Requesters drive requests and receive handshakes/responses.
  modport master (
    output req_valid_0, req_valid_1, req_addr_0, req_addr_1,
    input  req_ready_0, req_ready_1,
    input  rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1, rsp_err_0, rsp_err_1
  );

  // The arbiter accepts requests and returns responses.
  modport slave (
    input  req_valid_0, req_valid_1, req_addr_0, req_addr_1,
    output req_ready_0, req_ready_1,
    output rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1, rsp_err_0, rsp_err_1
  );

endinterface

// File: rtl/lmac_rr_arb2.sv
// Two-way round-robin grant: under contention the requester not served last wins.
module lmac_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant from the request vector and last-served index.
  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/lmac_reg_rd_arb.sv
// Arbitrates two requesters onto the single MAC register-read port, with
// a per-read timeout and a saturating count of abandoned reads.
module lmac_reg_rd_arb
  import lmac_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
  input  logic                    clk,
  input  logic                    rst,
  lmac_reg_rd_arb_if.slave        req_if,
  output logic [15:0]             host_addr_reg,
  output logic                    reg_rd_start,
  input  logic                    reg_rd_done_out,
  input  logic [31:0]             FMAC_REGDOUT,
  output logic [7:0]              timeout_cnt
);

  localparam int unsigned    CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  rd_state_e        state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [15:0]      host_addr_q, host_addr_d;
  logic             start_q, start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tmo_cnt_q, tmo_cnt_d;
  logic [1:0][31:0] rsp_data_q, rsp_data_d;
  logic [1:0]       rsp_err_q, rsp_err_d;

  logic [1:0] req_valid;
  logic [1:0] grant;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [1:0] hs;
  logic       timeout_hit;

  assign req_valid   = {req_if.req_valid_1, req_if.req_valid_0};
  assign hs          = req_valid & req_ready;
  assign timeout_hit = (cnt_q == CNT_MAX);

  lmac_rr_arb2 u_arb (
    .valid (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one read in flight; a done seen alongside the timeout still counts as done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|hs) state_d = ST_WAIT;
      ST_WAIT: if (reg_rd_done_out || timeout_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and response strobes; grants are held off while a previous done lingers.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == ST_IDLE && !reg_rd_done_out) req_ready = grant;
    if (state_q == ST_RESP) rsp_valid = owner_q ? 2'b10 : 2'b01;
  end

  // Datapath next values: latch request, count WAIT cycles, capture result.
  always_comb begin
    owner_d     = owner_q;
    last_d      = last_q;
    host_addr_d = host_addr_q;
    start_d     = start_q;
    cnt_d       = cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (|hs) begin
          owner_d     = hs[1];
          host_addr_d = hs[1] ? req_if.req_addr_1 : req_if.req_addr_0;
          start_d     = 1'b1;
          cnt_d       = '0;
        end
      end
      ST_WAIT: begin
        if (reg_rd_done_out) begin
          start_d             = 1'b0;
          rsp_data_d[owner_q] = FMAC_REGDOUT;
          rsp_err_d[owner_q]  = 1'b0;
        end else if (timeout_hit) begin
          start_d             = 1'b0;
          rsp_data_d[owner_q] = ERR_DATA;
          rsp_err_d[owner_q]  = 1'b1;
          tmo_cnt_d           = sat_inc8(tmo_cnt_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: last_d = owner_q;
      default: ;
    endcase
  end

  // Datapath registers; reset abandons any read in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      host_addr_q <= '0;
      start_q     <= 1'b0;
      cnt_q       <= '0;
      tmo_cnt_q   <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= '0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      host_addr_q <= host_addr_d;
      start_q     <= start_d;
      cnt_q       <= cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign host_addr_reg      = host_addr_q;
  assign reg_rd_start       = start_q;
  assign timeout_cnt        = tmo_cnt_q;
  assign req_if.req_ready_0 = req_ready[0];
  assign req_if.req_ready_1 = req_ready[1];
  assign req_if.rsp_valid_0 = rsp_valid[0];
  assign req_if.rsp_valid_1 = rsp_valid[1];
  assign req_if.rsp_data_0  = rsp_data_q[0];
  assign req_if.rsp_data_1  = rsp_data_q[1];
  assign req_if.rsp_err_0   = rsp_err_q[0];
  assign req_if.rsp_err_1   = rsp_err_q[1];

endmodule

// File: tb/tb_lmac_reg_rd_arb.sv
// Scoreboard bench for lmac_reg_rd_arb with a simple MAC read model.
module tb_lmac_reg_rd_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] host_addr_reg;
  logic        reg_rd_start;
  logic        mac_done = 1'b0;
  logic [31:0] mac_data = '0;
  logic [7:0]  timeout_cnt;

  lmac_reg_rd_arb_if bus ();

  lmac_reg_rd_arb #(
    .TIMEOUT_CYCLES (255),
    .ERR_DATA       (32'hFFFF_FFFF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_if          (bus),
    .host_addr_reg   (host_addr_reg),
    .reg_rd_start    (reg_rd_start),
    .reg_rd_done_out (mac_done),
    .FMAC_REGDOUT    (mac_data),
    .timeout_cnt     (timeout_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int unsigned hs_cyc = 0;
  int unsigned last_rsp_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // MAC model: done mac_lat cycles after a start rises, held mac_hold cycles; mac_lat 0 = never.
  int unsigned mac_lat  = 3;
  int unsigned mac_hold = 1;
  bit          start_seen = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (reg_rd_start && !start_seen && mac_lat != 0) begin
        start_seen = 1'b1;
        repeat (mac_lat) @(negedge clk);
        mac_data = (host_addr_reg == 16'h0010) ? 32'h1234_5678 : {16'hD0D0, host_addr_reg};
        mac_done = 1'b1;
        repeat (mac_hold) @(negedge clk);
        mac_done = 1'b0;
      end
      if (!reg_rd_start) start_seen = 1'b0;
    end
  end

  // Monitor: every response strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (bus.rsp_valid_0 || bus.rsp_valid_1)) begin
      exp_t e;
      int   p;
      last_rsp_cyc = cyc;
      chk("rsp_one_hot", {bus.rsp_valid_1, bus.rsp_valid_0} & 2'b11,
          bus.rsp_valid_1 ? 32'd2 : 32'd1);
      p = bus.rsp_valid_1 ? 1 : 0;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got response on port %0d, required none", p);
      end else begin
        e = sb.pop_front();
        chk("rsp_port", p, e.port);
        chk("rsp_data", p ? bus.rsp_data_1 : bus.rsp_data_0, e.data);
        chk("rsp_err", {31'd0, p ? bus.rsp_err_1 : bus.rsp_err_0}, {31'd0, e.err});
      end
    end
  end

  task automatic set_req(input int p, input logic v, input logic [15:0] a);
    if (p == 0) begin bus.req_valid_0 = v; bus.req_addr_0 = a; end
    else        begin bus.req_valid_1 = v; bus.req_addr_1 = a; end
  endtask

  // Raise a request and hold it until the handshake edge (bounded).
  task automatic do_req(input int p, input logic [15:0] a);
    int unsigned n = 0;
    @(negedge clk);
    set_req(p, 1'b1, a);
    while (n < 600) begin
      #1;
      if ((p == 0) ? bus.req_ready_0 : bus.req_ready_1) begin
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        set_req(p, 1'b0, 16'h0000);
        return;
      end
      @(negedge clk);
      n++;
    end
    set_req(p, 1'b0, 16'h0000);
    n_tests++;
    n_fail++;
    $display("FAIL handshake_timeout: port %0d got no ready, required ready within 600 cycles", p);
  endtask

  task automatic push(input int p, input logic [31:0] d, input logic e);
    exp_t x;
    x.port = p; x.data = d; x.err = e;
    sb.push_back(x);
  endtask

  task automatic drain(input string name, input int unsigned bound);
    int unsigned n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000 ns");
    $fatal(1);
  end

  initial begin
    int unsigned h0;
    int unsigned n;
    bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
    bus.req_addr_0  = '0;   bus.req_addr_1  = '0;

    // Reset values.
    #1;
    chk("rst_host_addr", host_addr_reg, 0);
    chk("rst_start", reg_rd_start, 0);
    chk("rst_rsp_valid", {bus.rsp_valid_1, bus.rsp_valid_0}, 0);
    chk("rst_rsp_data0", bus.rsp_data_0, 0);
    chk("rst_rsp_data1", bus.rsp_data_1, 0);
    chk("rst_rsp_err", {bus.rsp_err_1, bus.rsp_err_0}, 0);
    chk("rst_timeout_cnt", timeout_cnt, 0);

    // Both requesters valid from reset: grants 0,1,0,1.
    set_req(0, 1'b1, 16'h0020);
    set_req(1, 1'b1, 16'h0030);
    push(0, 32'hD0D0_0020, 1'b0);
    push(1, 32'hD0D0_0030, 1'b0);
    push(0, 32'hD0D0_0020, 1'b0);
    push(1, 32'hD0D0_0030, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      #1;
      while (!(bus.req_ready_0 || bus.req_ready_1) && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("rr_grant", {bus.req_ready_1, bus.req_ready_0}, (k % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge clk);
      #1;
      if (k == 3) begin
        set_req(0, 1'b0, 16'h0000);
        set_req(1, 1'b0, 16'h0000);
      end
      chk("rr_host_addr", host_addr_reg, (k % 2 == 0) ? 32'h0020 : 32'h0030);
      chk("rr_start", reg_rd_start, 1);
      @(negedge clk);
    end
    drain("rr_drain", 50);

    // Single read, done 3 cycles after start: latency 5, data then held.
    push(0, 32'h1234_5678, 1'b0);
    do_req(0, 16'h0010);
    drain("t1_drain", 50);
    chk("t1_latency", last_rsp_cyc - hs_cyc, 5);
    repeat (3) @(negedge clk);
    chk("t1_hold_data0", bus.rsp_data_0, 32'h1234_5678);
    chk("t1_hold_err0", bus.rsp_err_0, 0);
    chk("t1_hold_data1", bus.rsp_data_1, 32'hD0D0_0030);
    chk("t1_rsp_valid_low", {bus.rsp_valid_1, bus.rsp_valid_0}, 0);

    // MAC never answers: timeout after 256 WAIT cycles.
    mac_lat = 0;
    push(0, 32'hFFFF_FFFF, 1'b1);
    do_req(0, 16'h0040);
    drain("t3_drain", 400);
    chk("t3_latency", last_rsp_cyc - hs_cyc, 257);
    chk("t3_timeout_cnt", timeout_cnt, 1);

    // Done lingers 4 cycles past the response: req1 waits for it to fall.
    mac_lat  = 3;
    mac_hold = 5;
    push(0, 32'hD0D0_0044, 1'b0);
    push(1, 32'hD0D0_0050, 1'b0);
    do_req(0, 16'h0044);
    h0 = hs_cyc;
    set_req(1, 1'b1, 16'h0050);
    n = 0;
    @(negedge clk);
    #1;
    while (!bus.req_ready_1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t4_ready1_done", mac_done, 0);
    chk("t4_ready1_cycle", cyc - h0, 9);
    @(posedge clk);
    #1;
    set_req(1, 1'b0, 16'h0000);
    drain("t4_drain", 50);
    n = 0;
    while (mac_done && n < 20) begin @(negedge clk); n++; end
    mac_hold = 1;

    // Reset two cycles into WAIT abandons the read.
    mac_lat = 0;
    do_req(1, 16'h0060);
    repeat (2) @(negedge clk);
    chk("t5_start_before", reg_rd_start, 1);
    chk("t5_addr_before", host_addr_reg, 32'h0060);
    rst = 1'b1;
    #1;
    chk("t5_start_rst", reg_rd_start, 0);
    chk("t5_addr_rst", host_addr_reg, 0);
    chk("t5_tmo_rst", timeout_cnt, 0);
    chk("t5_data0_rst", bus.rsp_data_0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    mac_lat = 3;
    push(1, 32'hD0D0_0070, 1'b0);
    do_req(1, 16'h0070);
    drain("t5_drain", 50);
    chk("t5_latency", last_rsp_cyc - hs_cyc, 5);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
